// File: rtl/vector_dot_product_loader.sv
// Collects VECTOR_SIZE element pairs into two vectors, restarts the dot-product
// stage, captures its result and hands it downstream with a valid/ready handshake.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_LOAD   | accepting element pairs, in_ready high
// S_START  | one-cycle dp_start pulse to the dot-product stage
// S_WAIT   | waiting for the first dp_valid, then capture dp_result
// S_OUTPUT | out_valid high, holding out_result until out_ready
module vector_dot_product_loader #(
    parameter int WORD_WIDTH  = 31,
    parameter int VECTOR_SIZE = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [WORD_WIDTH-1:0]                   in_a,
    input  logic [WORD_WIDTH-1:0]                   in_b,
    output logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0]  vec1,
    output logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0]  vec2,
    output logic                                    dp_start,
    input  logic [WORD_WIDTH-1:0]                   dp_result,
    input  logic                                    dp_valid,
    output logic [WORD_WIDTH-1:0]                   out_result,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    busy
);

    localparam int IDX_W = $clog2(VECTOR_SIZE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VECTOR_SIZE - 1);
    localparam logic [WORD_WIDTH-1:0] M31_P = WORD_WIDTH'(64'h7FFF_FFFF);

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_OUTPUT
    } state_t;

    state_t                                 state_q, state_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
    logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] vec1_q, vec1_d;
    logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] vec2_q, vec2_d;
    logic [WORD_WIDTH-1:0]                  out_result_q, out_result_d;

    // p itself is the non-canonical encoding of zero in the M31 field
    function automatic logic [WORD_WIDTH-1:0] canon(input logic [WORD_WIDTH-1:0] v);
        return (v == M31_P) ? '0 : v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_LOAD;
            idx_q        <= '0;
            vec1_q       <= '0;
            vec2_q       <= '0;
            out_result_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            vec1_q       <= vec1_d;
            vec2_q       <= vec2_d;
            out_result_q <= out_result_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        vec1_d       = vec1_q;
        vec2_d       = vec2_q;
        out_result_d = out_result_q;
        in_ready     = 1'b0;
        dp_start     = 1'b0;
        out_valid    = 1'b0;

        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    vec1_d[idx_q] = canon(in_a);
                    vec2_d[idx_q] = canon(in_b);
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_START;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_START: begin
                // dp_valid may still be high from the previous run; not sampled here
                dp_start = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (dp_valid) begin
                    out_result_d = dp_result;
                    state_d      = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    assign vec1       = vec1_q;
    assign vec2       = vec2_q;
    assign out_result = out_result_q;
    assign busy       = (state_q != S_LOAD);

endmodule

// File: tb/tb_vector_dot_product_loader.sv
// Directed bench for vector_dot_product_loader with a behavioural M31
// dot-product stage whose dp_valid level stays high until the next dp_start.
module tb_vector_dot_product_loader;

    localparam int WW = 31;
    localparam int VS = 16;
    localparam logic [63:0] P = 64'h7FFF_FFFF;

    typedef logic [WW-1:0] word_t;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    word_t                   in_a = '0;
    word_t                   in_b = '0;
    logic [VS-1:0][WW-1:0]   vec1;
    logic [VS-1:0][WW-1:0]   vec2;
    logic                    dp_start;
    word_t                   dp_result = '0;
    logic                    dp_valid = 1'b1;
    word_t                   out_result;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic                    busy;

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0;
    int dp_cnt = 0;

    vector_dot_product_loader #(.WORD_WIDTH(WW), .VECTOR_SIZE(VS)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .vec1(vec1), .vec2(vec2), .dp_start(dp_start),
        .dp_result(dp_result), .dp_valid(dp_valid),
        .out_result(out_result), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic word_t dot_mod();
        logic [63:0] acc = 0;
        for (int i = 0; i < VS; i++)
            acc = (acc + ((64'(vec1[i]) * 64'(vec2[i])) % P)) % P;
        return word_t'(acc);
    endfunction

    // dot-product stage model: 3 cycles after restart, result held as a level
    always @(posedge clk) begin
        if (dp_start) begin
            n_start++;
            dp_valid <= 1'b0;
            dp_cnt   <= 3;
        end else if (dp_cnt != 0) begin
            dp_cnt <= dp_cnt - 1;
            if (dp_cnt == 1) begin
                dp_valid  <= 1'b1;
                dp_result <= dot_mod();
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input word_t a, input word_t b);
        bit accepted = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int k = 0; k < 50; k++) begin
            if (in_ready) begin
                tick();
                accepted = 1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!accepted) chk("accept_timeout", 0, 1);
    endtask

    task automatic load_vec(input word_t av[VS], input word_t bv[VS], input int gap, input int npairs);
        int base = n_start;
        for (int i = 0; i < npairs; i++) begin
            if (i == VS - 1) chk("no_early_start", 64'(n_start - base), 0);
            send_pair(av[i], bv[i]);
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic wait_out(input string tag);
        for (int k = 0; k < 60; k++) begin
            if (out_valid) break;
            tick();
        end
        chk(tag, out_valid, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_vec1"}, (vec1 == '0), 1);
        chk({tag, "_vec2"}, (vec2 == '0), 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_result"}, out_result, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    word_t av[VS];
    word_t bv[VS];
    int    base;
    word_t held;

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_dp_start", dp_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_vec1", (vec1 == '0), 1);
        chk("rst_vec2", (vec2 == '0), 1);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // all ones, in_valid held high; stale dp_valid from reset must be ignored
        for (int i = 0; i < VS; i++) begin av[i] = 1; bv[i] = 1; end
        base = n_start;
        load_vec(av, bv, 0, VS);
        chk("ones_busy", busy, 1);
        wait_out("ones_out_valid");
        chk("ones_result", out_result, 16);
        chk("ones_one_start", 64'(n_start - base), 1);

        // downstream stall: everything held, no new pair taken
        held = out_result;
        in_valid = 1'b1;
        in_a = 31'd77;
        in_b = 31'd77;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_result", out_result, 64'(held));
            chk("stall_in_ready", in_ready, 0);
        end
        chk("stall_vec1_kept", vec1[0], 1);
        in_valid = 1'b0;
        drain();
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
        chk("release_out_result_kept", out_result, 16);

        // ramp with idle gaps
        for (int i = 0; i < VS; i++) begin av[i] = word_t'(i); bv[i] = 1; end
        load_vec(av, bv, 3, VS);
        wait_out("ramp_out_valid");
        chk("ramp_result", out_result, 120);
        for (int i = 0; i < VS; i++) chk("ramp_vec1", vec1[i], 64'(i));
        drain();

        // 2^30 * 2^30 summed 16 times reduces to 4 mod 2^31-1
        for (int i = 0; i < VS; i++) begin av[i] = 31'h4000_0000; bv[i] = 31'h4000_0000; end
        load_vec(av, bv, 0, VS);
        wait_out("big_out_valid");
        chk("big_result", out_result, 4);
        drain();

        // non-canonical zero
        for (int i = 0; i < VS; i++) begin av[i] = 31'h7FFF_FFFF; bv[i] = 5; end
        load_vec(av, bv, 1, VS);
        wait_out("canon_out_valid");
        chk("canon_vec1_zero", (vec1 == '0), 1);
        chk("canon_vec2_0", vec2[0], 5);
        chk("canon_vec2_15", vec2[VS-1], 5);
        chk("canon_result", out_result, 0);
        drain();

        // reset after 7 pairs, then a full load must start at index 0
        for (int i = 0; i < VS; i++) begin av[i] = 9; bv[i] = 9; end
        load_vec(av, bv, 0, 7);
        chk("partial_vec1_6", vec1[6], 9);
        chk("partial_vec1_7", vec1[7], 0);
        tick();
        tick();
        chk("partial_persist", vec1[6], 9);
        chk("partial_not_busy", busy, 0);
        pulse_reset("rst_mid_load");
        for (int i = 0; i < VS; i++) begin av[i] = word_t'(i + 1); bv[i] = 2; end
        load_vec(av, bv, 0, VS);
        chk("after_rst_vec1_0", vec1[0], 1);
        chk("after_rst_vec1_15", vec1[VS-1], 16);
        wait_out("after_rst_out_valid");
        chk("after_rst_result", out_result, 272);
        drain();

        // reset while waiting for the result
        for (int i = 0; i < VS; i++) begin av[i] = 3; bv[i] = 3; end
        load_vec(av, bv, 0, VS);
        chk("start_pulse", dp_start, 1);
        tick();
        chk("wait_no_start", dp_start, 0);
        chk("wait_busy", busy, 1);
        chk("wait_no_valid", out_valid, 0);
        pulse_reset("rst_mid_wait");
        for (int c = 0; c < 6; c++) tick();
        chk("ignore_dp_valid_in_load", busy, 0);
        for (int i = 0; i < VS; i++) begin av[i] = 1; bv[i] = 1; end
        base = n_start;
        load_vec(av, bv, 0, VS);
        wait_out("final_out_valid");
        chk("final_result", out_result, 16);
        chk("final_one_start", 64'(n_start - base), 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vector_dot_product_loader.md
VECTOR_DOT_PRODUCT_LOADER -- requirements
Module: vector_dot_product_loader

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 31, M31 field element width.
REQ-002 SHALL have parameter VECTOR_SIZE, default 16, elements per vector; power of two, >= 2.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  element pair offered.
- in_ready  output  1  loader accepts a pair.
- in_a  input  WORD_WIDTH  element for vector 1.
- in_b  input  WORD_WIDTH  element for vector 2.
- vec1  output  WORD_WIDTH x VECTOR_SIZE  assembled vector 1, drives the dot-product stage.
- vec2  output  WORD_WIDTH x VECTOR_SIZE  assembled vector 2, drives the dot-product stage.
- dp_start  output  1  one-cycle restart pulse to the dot-product stage's synchronous reset.
- dp_result  input  WORD_WIDTH  dot-product result.
- dp_valid  input  1  dot-product result valid (level).
- out_result  output  WORD_WIDTH  captured dot product.
- out_valid  output  1  result offered downstream.
- out_ready  input  1  downstream accepts the result.
- busy  output  1  high in any state other than LOAD.

Function
REQ-004 SHALL implement the FSM LOAD -> START -> WAIT -> OUTPUT -> LOAD.
REQ-005 In LOAD, SHALL drive in_ready=1; all other states SHALL drive in_ready=0.
REQ-006 SHALL accept a pair on any clk edge where in_valid and in_ready are both high.
REQ-007 SHALL store an accepted pair at vec1[idx] and vec2[idx], then increment idx. idx is a $clog2(VECTOR_SIZE)-bit counter.
REQ-008 SHALL canonicalise each element before storing: a value equal to 2^31-1 is stored as 0; all others are stored unchanged.
REQ-009 On accepting the pair at idx=VECTOR_SIZE-1, SHALL enter START and wrap idx to 0.
REQ-010 In START, SHALL assert dp_start=1 for exactly one cycle and then enter WAIT; dp_start SHALL be 0 in every other state.
REQ-011 In WAIT, SHALL ignore dp_valid during the START cycle, since a stale high is possible. In WAIT, on the first cycle with dp_valid=1, SHALL capture dp_result into out_result and enter OUTPUT.
REQ-012 In OUTPUT, SHALL hold out_valid=1 and keep out_result stable until out_ready=1. On that handshake edge, SHALL enter LOAD with out_valid=0.
REQ-013 vec1/vec2 SHALL stay stable from START until leaving OUTPUT.
REQ-014 vec1/vec2 writes SHALL occur only on accepted LOAD handshakes.
REQ-015 out_result SHALL change only on WAIT capture.
REQ-016 With in_valid low in LOAD, SHALL leave idx and the vectors unchanged. Partially loaded vectors SHALL persist indefinitely.
REQ-017 End-to-end latency SHALL be: last accept edge -> START (1 cycle) -> WAIT, with capture on the first dp_valid edge, then out_valid high the following cycle.
REQ-018 A new pair SHALL not be accepted in the same cycle as the OUTPUT handshake; in_ready first rises in the cycle after it.

Reset
REQ-019 Asserting reset, in any state including mid-LOAD or mid-WAIT, SHALL immediately force all of the following:
- state=LOAD
- idx=0
- in_ready=1 (once the FSM is in LOAD)
- dp_start=0
- out_valid=0
- out_result=0
- busy=0
- all vec1/vec2 elements=0
REQ-020 After reset, the first accepted pair SHALL be stored at index 0. A dp_valid arriving while in LOAD SHALL be ignored.

Verification
REQ-021 Load 16 pairs of a=1, b=1 with in_valid held high. Expected: one dp_start pulse, out_result=16, out_valid=1.
REQ-022 Load a=i, b=1 for i=0..15, with in_valid gaps of 3 idle cycles. Expected: vec1[i]=i, result 120, no dp_start before the 16th accept.
REQ-023 Load a=b=2^30 for all 16 pairs. Expected: result 4 (2^60 mod p = 2^29; 16*2^29 = 2^33 mod p = 4).
REQ-024 Load a=0x7FFFFFFF, b=5 for all 16 pairs. Expected: vec1 all 0, result 0.
REQ-025 Hold out_ready=0 for 5 cycles in OUTPUT. Expected: out_valid and out_result stable, in_ready=0. Release out_ready: in_ready=1 on the next cycle.
REQ-026 Assert reset after 7 pairs are loaded, and again during WAIT. Expected after each: idx=0, out_valid=0, vectors zeroed. A subsequent full load still yields the correct result.
